// File: rtl/srlatch_arb_pkg.sv
// srlatch_arb_pkg: shared types, defaults and helpers for the SR-latch arbiter
package srlatch_arb_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, RELEASE, DONE, ERROR} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT = 255;
  function automatic int cnt_width(input int max_val);
    int w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction
  // Scans downward so the last hit is the first set bit at or above p, modulo n
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p, input int n);
    logic [3:0] w = p;
    logic [3:0] idx;
    for (int i = 15; i >= 0; i--) begin
      idx = 4'((int'(p) + i) % n);
      if (i < n && r[idx]) w = idx;
    end
    return w;
  endfunction
endpackage

// File: rtl/srlatch_sync.sv
// srlatch_sync: multi-stage flop synchroniser with synchronous clear
module srlatch_sync #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] ff [STAGES];
  always_ff @(posedge clk) begin
    if (rst) ff <= '{default: '0};
    else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/srlatch_arbiter.sv
// srlatch_arbiter: round-robin sharing of one async four-phase SR latch among clocked requesters
module srlatch_arbiter
  import srlatch_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] done,
  output logic             q_out,
  output logic             err,
  output logic             lat_s,
  output logic             lat_r,
  input  logic             lat_q,
  input  logic             lat_ack
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(TIMEOUT);
  state_t state, state_n;
  logic [IW-1:0] rr, rr_n, gidx, gidx_n, pick;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] done_n;
  logic lat_s_n, lat_r_n, q_n, err_n, ack_s, q_s, expired;
  srlatch_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d({lat_ack, lat_q}),
    .q({ack_s, q_s})
  );
  assign pick = IW'(rr_pick(16'(req), 4'(rr), N_REQ));
  // cnt counts completed wait cycles, so the limit trips as it would reach TIMEOUT
  assign expired = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    rr_n = rr;
    gidx_n = gidx;
    lat_s_n = lat_s;
    lat_r_n = lat_r;
    q_n = q_out;
    err_n = err;
    done_n = '0;
    unique case (state)
      IDLE: if (|req && !ack_s) begin
        state_n = DRIVE;
        gidx_n = pick;
        lat_s_n = op[pick];
        lat_r_n = !op[pick];
      end
      DRIVE: if (ack_s) begin
        state_n = RELEASE;
        q_n = q_s;
        lat_s_n = 1'b0;
        lat_r_n = 1'b0;
      end else if (expired) begin
        state_n = ERROR;
        lat_s_n = 1'b0;
        lat_r_n = 1'b0;
        err_n = 1'b1;
      end
      RELEASE: if (!ack_s) begin
        state_n = DONE;
        done_n[gidx] = 1'b1;
      end else if (expired) begin
        state_n = ERROR;
        err_n = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        rr_n = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
      end
      ERROR: state_n = ERROR;
      default: state_n = IDLE;
    endcase
    cnt_n = (state_n != state) ? '0 : ((state == DRIVE || state == RELEASE) ? cnt + CW'(1) : cnt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      gidx <= '0;
      cnt <= '0;
      lat_s <= 1'b0;
      lat_r <= 1'b0;
      done <= '0;
      q_out <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      rr <= rr_n;
      gidx <= gidx_n;
      cnt <= cnt_n;
      lat_s <= lat_s_n;
      lat_r <= lat_r_n;
      done <= done_n;
      q_out <= q_n;
      err <= err_n;
    end
  end
endmodule

// File: doc/srlatch_arbiter.md
Name: srlatch_arbiter

Overview:
- Synchronous controller that shares one asynchronous bundled-data SR latch (s/r in, q/ack out, four-phase handshake) among N_REQ clocked requesters.
- Selects one requester round-robin and drives the latch's s or r.
- Synchronises ack and q, completes the full four-phase return-to-zero, then returns q and a one-cycle done pulse to the winner.
- Sits between the clocked control fabric and the async latch instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SYNC_STAGES, 2, flop stages on lat_ack and lat_q (>=2).
- TIMEOUT, 255, max cycles in any wait state before error. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- op  input  N_REQ  per-requester command: 1=set, 0=reset. Must be stable while req is high.
- done  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- q_out  output  1  latch value captured for the last completed transaction. Valid when any done is high; holds its value otherwise.
- err  output  1  sticky timeout flag.
- lat_s  output  1  latch set input.
- lat_r  output  1  latch reset input.
- lat_q  input  1  latch q (asynchronous).
- lat_ack  input  1  latch ack (asynchronous).

Behaviour:
- Reset (on any rising edge with rst=1, including mid-transaction):
  - state=IDLE; lat_s=lat_r=0; done=0; q_out=0; err=0.
  - rr pointer=0; timeout counter=0; synchroniser flops cleared.
- ack_s and q_s are the SYNC_STAGES-flop synchronised versions of lat_ack and lat_q.
- lat_s and lat_r are registered outputs and are never high together.
- States:
  - IDLE:
    - Grant only if some req bit is 1 and ack_s=0. The ack_s=0 condition covers a latch still completing a cycle that began before reset.
    - Winner = first set req bit scanning from rr upward, wrapping modulo N_REQ. Register its index as gidx.
    - Drive lat_s=op[gidx] and lat_r=!op[gidx], then go to DRIVE.
    - Latency: req high in cycle n gives lat_s/lat_r high in cycle n+1.
  - DRIVE:
    - Hold lat_s/lat_r and wait for ack_s=1.
    - On ack_s=1: capture q_s into q_out, drop lat_s and lat_r, go to RELEASE.
  - RELEASE:
    - Keep lat_s=lat_r=0 and wait for ack_s=0.
    - Then go to DONE.
  - DONE:
    - done[gidx]=1 for exactly this cycle.
    - rr=(gidx+1) mod N_REQ. Next state IDLE.
    - A requester that keeps req high is eligible again only after the other pending requesters have been served (round-robin).
  - ERROR:
    - Entered when the counter reaches TIMEOUT in DRIVE or RELEASE.
    - lat_s=lat_r=0, err=1, no done pulse, no further grants.
    - Only rst exits ERROR.
- Timeout counter: cleared on every state entry; increments each cycle spent in DRIVE or RELEASE.
- Request withdrawn (req[gidx] dropped) after grant: ignored; the transaction completes and done[gidx] still pulses.
- op changes after grant: ignored; the command is fixed at grant time.
- Back-to-back: minimum transaction is 4 + 2*SYNC_STAGES cycles plus latch delay. No new grant is issued in the DONE cycle.

Decomposition:
- Package srlatch_arb_pkg:
  - state enum {IDLE, DRIVE, RELEASE, DONE, ERROR}.
  - Default constants for SYNC_STAGES and TIMEOUT.
  - clog2-style counter-width constant function.
- One sub-module, srlatch_sync: parameterised width and stage-count flop synchroniser, reset by rst. Instantiated once, width 2, for {lat_ack, lat_q}.
- Round-robin pick is a combinational function in the package.

Test Plan:
- Single set: req=4'b0001, op[0]=1; latch model acks 10 cycles after s.
  -> lat_s=1 one cycle after req.
  -> lat_s=0 SYNC_STAGES cycles after ack rises.
  -> done[0] pulses once after ack falls; q_out=1.
- Round-robin: req=4'b1011 held, op all 0.
  -> grant order 0,1,3,0,1,3.
  -> lat_r asserted each time, lat_s never.
  -> q_out=0 at every done pulse.
- Timeout: latch model never raises ack, TIMEOUT=255.
  -> err=1 after 255 cycles in DRIVE; lat_s/lat_r=0.
  -> later requests get no done until rst.
- Reset mid-handshake: rst for 1 cycle while in DRIVE with ack low; latch model later raises then lowers ack.
  -> all outputs reset.
  -> no grant issued while ack_s=1.
  -> next request is served normally after ack_s returns to 0.
- Withdrawn request: req[2] pulses high for 1 cycle.
  -> transaction completes; done[2] pulses; rr then points to 3.
- Concurrent set/reset: req[0] op=1 and req[1] op=0 simultaneously.
  -> served in order 0 then 1; q_out=1 then 0.
  -> lat_s and lat_r never both high.
